// File: rtl/maf_frame_if.sv
// Frame-load and sample-stream bundle between the filter, the streamer and the downstream sink.
interface maf_frame_if #(
    parameter int N_SAMPLES = 256,
    parameter int DATA_W    = 8
);
    localparam int IDX_W = $clog2(N_SAMPLES);

    // A load is taken when frame_load & frame_ready, and a stream beat moves when m_valid & m_ready;
    // once m_valid is raised, data/index/last stay frozen until that beat moves.
    logic [N_SAMPLES-1:0][DATA_W-1:0] frame_in;
    logic                             frame_load;
    logic                             frame_ready;
    logic                             m_valid;
    logic                             m_ready;
    logic [DATA_W-1:0]                m_data;
    logic                             m_last;
    logic [IDX_W-1:0]                 m_index;

    modport master (
        input  frame_in, frame_load, m_ready,
        output frame_ready, m_valid, m_data, m_last, m_index
    );

    modport slave (
        output frame_in, frame_load, m_ready,
        input  frame_ready, m_valid, m_data, m_last, m_index
    );
endinterface

// File: rtl/maf_frame_streamer.sv
// Double-buffered frame-to-stream converter for the moving-average filter output.
// Optional MAF_SKIP_PAD_EN: drop the leading PAD zero-padded samples of each frame.
module maf_frame_streamer #(
    parameter int N_SAMPLES = 256,
    parameter int DATA_W    = 8,
    parameter int PAD       = 50
) (
    input  logic          clk,
    input  logic          rst,
    maf_frame_if.master   bus,
    output logic          busy,
    output logic          frame_done,
    output logic          overrun,
    output logic          dbg_state_o
);
    localparam int IDX_W = $clog2(N_SAMPLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);
`ifdef MAF_SKIP_PAD_EN
    localparam logic [IDX_W-1:0] START = IDX_W'(PAD);
`else
    localparam logic [IDX_W-1:0] START = '0;
`endif

    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_e;
    typedef logic [N_SAMPLES-1:0][DATA_W-1:0] frame_t;

    state_e           state_q, state_d;
    frame_t           act_q, act_d;
    frame_t           shd_q, shd_d;
    logic             shadow_full_q, shadow_full_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;
    logic             ovr_q, ovr_d;
    logic             load_acc;
    logic             beat;
    logic             last_beat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            act_q         <= '0;
            shd_q         <= '0;
            shadow_full_q <= 1'b0;
            idx_q         <= '0;
            done_q        <= 1'b0;
            ovr_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            act_q         <= act_d;
            shd_q         <= shd_d;
            shadow_full_q <= shadow_full_d;
            idx_q         <= idx_d;
            done_q        <= done_d;
            ovr_q         <= ovr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        act_d         = act_q;
        shd_d         = shd_q;
        shadow_full_d = shadow_full_q;
        idx_d         = idx_q;
        done_d        = 1'b0;
        load_acc      = bus.frame_load & ~shadow_full_q;
        ovr_d         = bus.frame_load & shadow_full_q;
        beat          = (state_q == STREAM) & bus.m_ready;
        last_beat     = beat & (idx_q == LAST_IDX);

        case (state_q)
            IDLE: begin
                if (load_acc) begin
                    act_d   = bus.frame_in;
                    idx_d   = START;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (last_beat) begin
                    done_d = 1'b1;
                    // A waiting shadow frame wins; otherwise a same-edge load goes straight to active.
                    if (shadow_full_q) begin
                        act_d         = shd_q;
                        idx_d         = START;
                        shadow_full_d = 1'b0;
                    end else if (load_acc) begin
                        act_d = bus.frame_in;
                        idx_d = START;
                    end else begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end
                end else begin
                    if (beat) begin
                        idx_d = idx_q + 1'b1;
                    end
                    if (load_acc) begin
                        shd_d         = bus.frame_in;
                        shadow_full_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.frame_ready = ~shadow_full_q;
    assign bus.m_valid     = (state_q == STREAM);
    assign bus.m_data      = act_q[idx_q];
    assign bus.m_index     = idx_q;
    assign bus.m_last      = (state_q == STREAM) & (idx_q == LAST_IDX);
    assign busy            = (state_q == STREAM) | shadow_full_q;
    assign frame_done      = done_q;
    assign overrun         = ovr_q;
    assign dbg_state_o     = state_q;
endmodule
